// File: rtl/alu_driver.sv
// Initiator for the 8-bit ALU: takes commands on a valid/ready port, drives registered
// operands to the ALU, samples its result after ALU_LAT cycles and queues it in a FWFT FIFO.
module alu_driver #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [7:0]       cmd_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    wait_q;
    logic             err_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [2:0]       alu_op_q;
    logic [7:0]       cmd_count_q;
    logic             ready_q, ready_d;
    logic [WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic accept, push, pop, legal;

    assign accept = cmd_valid && ready_q;
    assign push   = (state_q == DRIVE) && (wait_q == '0);
    assign pop    = rsp_ready && (cnt_q != '0);
    assign legal  = (cmd_op <= 3'd4);

    // Ready is registered from next-state so it reads 0 while reset is asserted.
    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = DRIVE;
        else if (push)
            state_d = IDLE;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        ready_d = (state_d == IDLE) && (cnt_d < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            err_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            cmd_count_q <= '0;
            ready_q     <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        wait_q      <= LW'(ALU_LAT - 1);
                        err_q       <= !legal;
                        cmd_count_q <= cmd_count_q + 8'd1;
                        if (legal) begin
                            alu_a_q  <= cmd_a;
                            alu_b_q  <= cmd_b;
                            alu_op_q <= cmd_op;
                        end
                    end
                end
                DRIVE: begin
                    if (push) begin
                        mem_q[wr_q] <= err_q ? {1'b1, {WIDTH{1'b0}}} : {1'b0, alu_out};
                        wr_q        <= wr_q + PW'(1);
                    end else begin
                        wait_q <= wait_q - LW'(1);
                    end
                end
                default: ;
            endcase
            if (pop)
                rd_q <= rd_q + PW'(1);
        end
    end

    assign cmd_ready  = ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = (cnt_q != '0);
    assign rsp_data   = mem_q[rd_q][WIDTH-1:0];
    assign rsp_err    = mem_q[rd_q][WIDTH];
    assign busy       = (state_q != IDLE);
    assign cmd_count  = cmd_count_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural 8-bit ALU attached to its operand outputs.
module tb_alu_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_opcode;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic [7:0] cmd_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_out = '0;
        case (alu_opcode)
            3'd0: alu_out = alu_a + alu_b;
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = ~alu_a;
            default: alu_out = '0;
        endcase
    end

    alu_driver #(.WIDTH(8), .FIFO_DEPTH(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .cmd_count(cmd_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a command and returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("send_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic e);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, d});
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst_count", {24'd0, cmd_count}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Basic add and its latency
        send(8'h5A, 8'hA5, 3'd0);
        chk("add_busy", {31'd0, busy}, 32'd1);
        chk("add_alu_a", {24'd0, alu_a}, 32'h5A);
        chk("add_early_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("add_late_valid", {31'd0, rsp_valid}, 32'd1);
        chk("add_idle", {31'd0, busy}, 32'd0);
        pop_chk("add", 8'hFF, 1'b0);

        send(8'hFF, 8'h01, 3'd0);
        pop_chk("add_wrap", 8'h00, 1'b0);
        send(8'h10, 8'h20, 3'd1);
        pop_chk("sub_wrap", 8'hF0, 1'b0);

        // Logic ops from a fresh count
        do_reset();
        send(8'hC3, 8'h3C, 3'd2);
        pop_chk("and", 8'h00, 1'b0);
        send(8'hC3, 8'h3C, 3'd3);
        pop_chk("or", 8'hFF, 1'b0);
        send(8'hC3, 8'h3C, 3'd4);
        pop_chk("not", 8'h3C, 1'b0);
        chk("count3", {24'd0, cmd_count}, 32'd3);

        // Illegal opcode leaves operands untouched
        send(8'h11, 8'h22, 3'd6);
        chk("ill_opcode_hold", {29'd0, alu_opcode}, 32'd4);
        chk("ill_alu_a_hold", {24'd0, alu_a}, 32'hC3);
        pop_chk("ill", 8'h00, 1'b1);
        chk("count4", {24'd0, cmd_count}, 32'd4);

        // Back-pressure: FIFO fills at 4, fifth waits for one pop
        send(8'h01, 8'h01, 3'd0);
        send(8'h02, 8'h02, 3'd0);
        send(8'h03, 8'h03, 3'd0);
        send(8'h04, 8'h04, 3'd0);
        cmd_a = 8'h05; cmd_b = 8'h05; cmd_op = 3'd0; cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd0);
        chk("full_head", {24'd0, rsp_data}, 32'h02);
        chk("full_count", {24'd0, cmd_count}, 32'd8);
        pop_chk("q0", 8'h02, 1'b0);
        send(8'h05, 8'h05, 3'd0);
        chk("count9", {24'd0, cmd_count}, 32'd9);
        pop_chk("q1", 8'h04, 1'b0);
        pop_chk("q2", 8'h06, 1'b0);
        pop_chk("q3", 8'h08, 1'b0);
        pop_chk("q4", 8'h0A, 1'b0);
        @(negedge clk);
        chk("drained", {31'd0, rsp_valid}, 32'd0);

        // Reset while a command is in flight with a response queued
        send(8'h20, 8'h01, 3'd0);
        @(posedge clk); #1;
        send(8'h30, 8'h01, 3'd0);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_count", {24'd0, cmd_count}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        send(8'h07, 8'h08, 3'd0);
        pop_chk("post_rst", 8'h0F, 1'b0);
        @(negedge clk);
        chk("post_rst_empty", {31'd0, rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
